button_debouncer: RTL



---
 rtl/button_debouncer_if.sv | 47 ++++
 rtl/button_debouncer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/button_debouncer_if.sv
// button_debouncer_if
// Bundles the pad-side inputs and the conditioned outputs of the button
// debouncer so the peripheral and the debouncer connect through one port.
//   buttons_raw : raw asynchronous pad levels (active-high)
//   clear_i     : per-bit clear of the sticky press flags
//   buttons_o   : debounced button state
//   pressed_o   : one-cycle pulse on debounced 0->1
//   released_o  : one-cycle pulse on debounced 1->0
//   latched_o   : sticky press flags
//   event_o     : OR of all press/release pulses, same cycle as the pulses
//   tick_o      : prescaler sample tick
// Modports: master drives buttons_raw/clear_i, slave (the debouncer) drives
// the conditioned outputs.
interface button_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] buttons_raw;
    logic [WIDTH-1:0] clear_i;
    logic [WIDTH-1:0] buttons_o;
    logic [WIDTH-1:0] pressed_o;
    logic [WIDTH-1:0] released_o;
    logic [WIDTH-1:0] latched_o;
    logic             event_o;
    logic             tick_o;

    modport master (
        output buttons_raw,
        output clear_i,
        input  buttons_o,
        input  pressed_o,
        input  released_o,
        input  latched_o,
        input  event_o,
        input  tick_o
    );

    modport slave (
        input  buttons_raw,
        input  clear_i,
        output buttons_o,
        output pressed_o,
        output released_o,
        output latched_o,
        output event_o,
        output tick_o
    );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer
// Input-conditioning stage for the Wishbone buttons/LEDs peripheral.
// Each raw pad bit is passed through a 2-flop synchroniser and then debounced
// independently: the debounced state only flips after the synchronised input
// has disagreed with it for STABLE_TICKS consecutive prescaler ticks. Any
// cycle of agreement restarts the window. Press/release pulses, a sticky
// press flag with per-bit clear, and an event strobe are produced alongside.
// Ports:
//   wb_clk_i : the only clock
//   wb_rst_i : synchronous active-high reset
//   bus      : button_debouncer_if.slave (raw inputs, clears, all outputs)
// Every output is driven straight from a flop.
module button_debouncer #(
    parameter int WIDTH        = 8,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 20
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    button_debouncer_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_s;
    logic             tick_r;
    logic             tick_s;
    logic [CNT_W-1:0] cnt_r [WIDTH];
    logic [CNT_W-1:0] cnt_s [WIDTH];
    logic [WIDTH-1:0] btn_r;
    logic [WIDTH-1:0] btn_s;
    logic [WIDTH-1:0] prs_r;
    logic [WIDTH-1:0] prs_s;
    logic [WIDTH-1:0] rel_r;
    logic [WIDTH-1:0] rel_s;
    logic [WIDTH-1:0] lat_r;
    logic [WIDTH-1:0] lat_s;
    logic             evt_r;
    logic             evt_s;

    // Prescaler next state. tick_r is the registered compare, so it is high
    // for exactly one cycle per period and first rises on the TICK_DIV-th
    // edge after reset (every edge when TICK_DIV is 1).
    always_comb begin
        tick_s = 1'b0;
        div_s  = div_r;
        if (div_r == DIV_LAST) begin
            div_s  = {DIV_W{1'b0}};
            tick_s = 1'b1;
        end else begin
            div_s  = div_r + DIV_W'(1);
            tick_s = 1'b0;
        end
    end

    // Per-bit debounce counters, state flips, pulses, sticky flags, event.
    always_comb begin
        btn_s = btn_r;
        prs_s = {WIDTH{1'b0}};
        rel_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_s[i] = cnt_r[i];
            if (s2_r[i] == btn_r[i]) begin
                // Agreement (including a bounce back) aborts any pending count.
                cnt_s[i] = {CNT_W{1'b0}};
            end else if (tick_r) begin
                if (cnt_r[i] == CNT_LAST) begin
                    cnt_s[i] = {CNT_W{1'b0}};
                    btn_s[i] = ~btn_r[i];
                    prs_s[i] = ~btn_r[i];
                    rel_s[i] = btn_r[i];
                end else begin
                    cnt_s[i] = cnt_r[i] + CNT_W'(1);
                end
            end else begin
                cnt_s[i] = cnt_r[i];
            end
        end
        // The flag is set from the registered pulse, so a clear arriving in
        // the pulse cycle loses to the set.
        lat_s = prs_r | (lat_r & ~bus.clear_i);
        evt_s = |(prs_s | rel_s);
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_r   <= {WIDTH{1'b0}};
            s2_r   <= {WIDTH{1'b0}};
            div_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
            btn_r  <= {WIDTH{1'b0}};
            prs_r  <= {WIDTH{1'b0}};
            rel_r  <= {WIDTH{1'b0}};
            lat_r  <= {WIDTH{1'b0}};
            evt_r  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            s1_r   <= bus.buttons_raw;
            s2_r   <= s1_r;
            div_r  <= div_s;
            tick_r <= tick_s;
            btn_r  <= btn_s;
            prs_r  <= prs_s;
            rel_r  <= rel_s;
            lat_r  <= lat_s;
            evt_r  <= evt_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
        end
    end

    assign bus.buttons_o  = btn_r;
    assign bus.pressed_o  = prs_r;
    assign bus.released_o = rel_r;
    assign bus.latched_o  = lat_r;
    assign bus.event_o    = evt_r;
    assign bus.tick_o     = tick_r;
endmodule
